bcd_scan_counter: RTL and testbench

- Two-digit BCD counter (00-99) with an internal step prescaler.
- Time-multiplexes its tens and units digits onto one 4-bit digit bus, with a one-hot digit select.
- Sits directly upstream of the seven_segment decoder: digit drives the decoder's 4-bit input i, and dig_sel drives the display digit enables.
- Provides the stimulus source that replaces bench-driven digit codes in the display path.

---
 rtl/bcd_scan_counter.sv | 112 +++++++++++
 tb/tb_bcd_scan_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD counter (00-99) with step prescaler, time-multiplexed onto a single digit bus.
// Optional LEADING_ZERO_BLANK_EN: blank a zero tens digit with code 4'b1111.
module bcd_scan_counter #(
  parameter int TICK_DIV = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic [0:3] digit,
  output logic [1:0] dig_sel,
  output logic       carry
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  logic [PW-1:0] pre, pre_nxt;
  logic [3:0]    tens, units, tens_nxt, units_nxt;
  logic          carry_nxt;
  logic          step;
  logic [SW-1:0] scan_cnt, scan_nxt;
  logic          sel_tens, sel_nxt;
  logic [3:0]    digit_nxt;

  // Count path: load beats step; carry only ever pulses on a wrapping step.
  always_comb begin
    pre_nxt   = pre;
    tens_nxt  = tens;
    units_nxt = units;
    carry_nxt = 1'b0;
    step      = en && (pre == PRE_LAST);
    if (load) begin
      tens_nxt  = clamp9(load_val[7:4]);
      units_nxt = clamp9(load_val[3:0]);
      pre_nxt   = '0;
    end else if (step) begin
      pre_nxt = '0;
      if (up_dn) begin
        if (units == 4'd9) begin
          units_nxt = 4'd0;
          if (tens == 4'd9) begin
            tens_nxt  = 4'd0;
            carry_nxt = 1'b1;
          end else begin
            tens_nxt = tens + 4'd1;
          end
        end else begin
          units_nxt = units + 4'd1;
        end
      end else begin
        if (units == 4'd0) begin
          units_nxt = 4'd9;
          if (tens == 4'd0) begin
            tens_nxt  = 4'd9;
            carry_nxt = 1'b1;
          end else begin
            tens_nxt = tens - 4'd1;
          end
        end else begin
          units_nxt = units - 4'd1;
        end
      end
    end else if (en) begin
      pre_nxt = pre + PW'(1);
    end
  end

  // digit is built from next-cycle count and select so it never lags dig_sel.
  always_comb begin
    scan_nxt  = (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);
    sel_nxt   = (scan_cnt == SCAN_LAST) ? ~sel_tens : sel_tens;
    digit_nxt = sel_nxt ? tens_nxt : units_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_nxt && (tens_nxt == 4'd0)) digit_nxt = 4'b1111;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      tens     <= 4'd0;
      units    <= 4'd0;
      carry    <= 1'b0;
      scan_cnt <= '0;
      sel_tens <= 1'b0;
      digit    <= 4'b0000;
    end else begin
      pre      <= pre_nxt;
      tens     <= tens_nxt;
      units    <= units_nxt;
      carry    <= carry_nxt;
      scan_cnt <= scan_nxt;
      sel_tens <= sel_nxt;
      digit    <= digit_nxt;
    end
  end

  assign count_bcd = {tens, units};
  assign dig_sel   = sel_tens ? 2'b10 : 2'b01;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized bench for bcd_scan_counter against an integer (0-99) reference model.
module tb_bcd_scan_counter;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count_bcd;
  logic [0:3] digit;
  logic [1:0] dig_sel;
  logic       carry;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain decimal count, prescaler and edges since reset.
  int   m_cnt = 0;
  int   m_pre = 0;
  int   m_scan = 0;
  logic m_carry = 1'b0;
  logic [7:0] exp_q[$];

  bcd_scan_counter #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count_bcd(count_bcd), .digit(digit),
    .dig_sel(dig_sel), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampn(input int n);
    return (n > 9) ? 9 : n;
  endfunction

  task automatic model_edge();
    if (load) begin
      m_cnt   = clampn(int'(load_val[7:4])) * 10 + clampn(int'(load_val[3:0]));
      m_pre   = 0;
      m_carry = 1'b0;
    end else if (en && m_pre == TICK_DIV - 1) begin
      m_pre = 0;
      if (up_dn) begin
        m_carry = (m_cnt == 99);
        m_cnt   = (m_cnt + 1) % 100;
      end else begin
        m_carry = (m_cnt == 0);
        m_cnt   = (m_cnt + 99) % 100;
      end
    end else begin
      if (en) m_pre++;
      m_carry = 1'b0;
    end
    m_scan++;
    exp_q.push_back(8'(((m_cnt / 10) << 4) | (m_cnt % 10)));
  endtask

  task automatic check_outputs();
    logic [7:0] e;
    logic       tens_sel;
    logic [3:0] ed;
    e        = exp_q.pop_front();
    tens_sel = ((m_scan / SCAN_DIV) % 2) == 1;
    ed       = tens_sel ? e[7:4] : e[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (tens_sel && e[7:4] == 4'd0) ed = 4'b1111;
`endif
    check("count", 32'(count_bcd), 32'(e));
    check("carry", 32'(carry), 32'(m_carry));
    check("dig_sel", 32'(dig_sel), tens_sel ? 32'd2 : 32'd1);
    check("digit", 32'(digit), 32'(ed));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(count_bcd), 32'h00);
    check({tag, "_digit"}, 32'(digit), 32'h0);
    check({tag, "_dig_sel"}, 32'(dig_sel), 32'h1);
    check({tag, "_carry"}, 32'(carry), 32'h0);
  endtask

  // Called at a falling edge: apply inputs, take one rising edge, check, return at next fall.
  task automatic cyc(input logic e, input logic u, input logic l, input logic [7:0] lv);
    en = e; up_dn = u; load = l; load_val = lv;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_scan = 0; m_carry = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    #2 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Count up from 00 through the 09 -> 10 rollover.
    repeat (48) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // 98, 99, 00 with carry, 01.
    cyc(1'b1, 1'b1, 1'b1, 8'h98);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // 01, 00, 99 down with carry, then switch to up mid-prescale.
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    repeat (9) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Hold 37 with en low; scan keeps alternating.
    cyc(1'b0, 1'b1, 1'b1, 8'h37);
    repeat (12) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);

    // Load coincident with a step at 99, using an out-of-range load value.
    cyc(1'b1, 1'b1, 1'b1, 8'h98);
    n = 0;
    while (!(m_cnt == 99 && m_pre == TICK_DIV - 1) && n < 200) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      n++;
    end
    check("reach_99_step", 32'(n < 200), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 8'hAF);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Random traffic.
    repeat (400)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 8'($urandom));

    // Asynchronous reset mid-count at 45, prescaler 2.
    cyc(1'b1, 1'b1, 1'b1, 8'h45);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single-digit count to exercise the tens slot showing zero.
    cyc(1'b0, 1'b1, 1'b1, 8'h05);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (40) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
